// File: rtl/key_debounce_bank_if.sv
// Key bank interface: raw key inputs plus the debounced level and event outputs.
// The master side drives the raw keys. The slave side is the debouncer.
interface key_debounce_bank_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] Key;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] fake_switch;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output Key,
    input  key_level,
    input  key_press,
    input  key_release,
    input  fake_switch,
    input  key_long
  );

  modport slave (
    input  Key,
    output key_level,
    output key_press,
    output key_release,
    output fake_switch,
    output key_long
  );
endinterface

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: a multi-channel key conditioner for the front-panel keys.
// Each channel does the following:
//   - synchronises its raw key through two flops;
//   - debounces the key with a counter;
//   - produces a clean level, single-cycle press and release pulses, and a toggle output.
// Everything runs on Div_CLK. Rst is synchronous and active-high.
// Optional feature: define KEY_DEBOUNCE_LONG_PRESS_EN to build per-channel hold
// counters that pulse key_long once per press after LONG_CYCLES cycles of hold.
// Without that macro, key_long is tied to zero.
module key_debounce_bank #(
  parameter int N_KEYS          = 2,
  parameter int DEB_CYCLES      = 12,
  parameter int LONG_CYCLES     = 20000,
  parameter int KEY_ACTIVE_HIGH = 1
) (
  input logic             Div_CLK,
  input logic             Rst,
  key_debounce_bank_if.slave kb
);

  localparam int                CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]     DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [N_KEYS-1:0] INV_MASK = (KEY_ACTIVE_HIGH != 0) ? '0 : '1;

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] st;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] fake;
  logic [CW-1:0]     cnt [N_KEYS];

  // Normalise polarity so that everything downstream treats 1 as pressed.
  assign key_in = kb.Key ^ INV_MASK;

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge Div_CLK) begin
    if (Rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Debounce counter and event generation.
  // The press/release pulses and the toggle update on the same edge that
  // commits the new stable level, so they line up exactly with key_level.
  always_ff @(posedge Div_CLK) begin
    if (Rst) begin
      st    <= '0;
      press <= '0;
      rel   <= '0;
      fake  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          st[i]    <= s2[i];
          cnt[i]   <= '0;
          press[i] <= s2[i];
          rel[i]   <= ~s2[i];
          if (s2[i]) begin
            fake[i] <= ~fake[i];
          end
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign kb.key_level   = st;
  assign kb.key_press   = press;
  assign kb.key_release = rel;
  assign kb.fake_switch = fake;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int            HW       = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_PRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0]     hold [N_KEYS];
  logic [N_KEYS-1:0] long_q;

  // Hold counters: each counter saturates, so key_long can fire at most once per press.
  always_ff @(posedge Div_CLK) begin
    if (Rst) begin
      long_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      long_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (!st[i]) begin
          hold[i] <= '0;
        end else if (hold[i] != LONG_MAX) begin
          hold[i] <= hold[i] + HW'(1);
          if (hold[i] == LONG_PRE) begin
            long_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign kb.key_long = long_q;
`else
  assign kb.key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce_bank.sv
// Testbench for key_debounce_bank.
// It builds two instances with N_KEYS=2, DEB_CYCLES=4 and LONG_CYCLES=10:
//   - an active-high instance, which carries most of the scenarios;
//   - an active-low instance, which gets one press.
// The long-press expectations depend on whether KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module tb_key_debounce_bank;

  typedef struct {
    logic       rst;
    logic [1:0] key;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] fake;
  } vec_t;

  logic Div_CLK;
  logic Rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  key_debounce_bank_if #(.N_KEYS(2)) kb_high();
  key_debounce_bank_if #(.N_KEYS(2)) kb_low();

  key_debounce_bank #(
    .N_KEYS(2), .DEB_CYCLES(4), .LONG_CYCLES(10), .KEY_ACTIVE_HIGH(1)
  ) dut_high (
    .Div_CLK(Div_CLK), .Rst(Rst), .kb(kb_high.slave)
  );

  key_debounce_bank #(
    .N_KEYS(2), .DEB_CYCLES(4), .LONG_CYCLES(10), .KEY_ACTIVE_HIGH(0)
  ) dut_low (
    .Div_CLK(Div_CLK), .Rst(Rst), .kb(kb_low.slave)
  );

  initial Div_CLK = 1'b0;
  always #5 Div_CLK = ~Div_CLK;

  // Drive both instances, take one clock edge, and settle 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] key_high, input logic [1:0] key_low);
    Rst         = rst;
    kb_high.Key = key_high;
    kb_low.Key  = key_low;
    @(posedge Div_CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Run n edges and watch one event bus:
  //   sel 0 = high press, sel 1 = high release, sel 2 = low press, sel 3 = high long.
  // The task reports how many edges had events, and the edge index and value of the last one.
  task automatic watchEvents(input logic [1:0] key_high, input logic [1:0] key_low, input int n,
                             input int sel, output int events, output int at_edge, output int value);
    logic [1:0] ev;
    events  = 0;
    at_edge = 0;
    value   = 0;
    for (int e = 1; e <= n; e++) begin
      applyStimulus(1'b0, key_high, key_low);
      case (sel)
        0:       ev = kb_high.key_press;
        1:       ev = kb_high.key_release;
        2:       ev = kb_low.key_press;
        default: ev = kb_high.key_long;
      endcase
      if (ev != 2'b00) begin
        events++;
        at_edge = e;
        value   = int'(ev);
      end
    end
  endtask

  task automatic addRows(input int n, input logic rst, input logic [1:0] key, input logic [1:0] level,
                         input logic [1:0] press, input logic [1:0] rel, input logic [1:0] fake);
    vec_t v;
    v.rst = rst; v.key = key; v.level = level; v.press = press; v.rel = rel; v.fake = fake;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int         ev;
    int         at;
    int         val;
    int         press_n;
    int         press_at;
    int         long_n;
    int         long_at;
    int         exp_long_n;
    logic [1:0] k;

    total = 0;
    bad   = 0;
    Rst   = 1'b1;
    kb_high.Key = 2'b00;
    kb_low.Key  = 2'b11;

    // The rows cover reset with both keys held, a release, a reset that arrives
    // mid-debounce, and a re-press followed by a release.
    addRows(3, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addRows(5, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addRows(1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11);
    addRows(1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
    addRows(5, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
    addRows(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);
    addRows(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    addRows(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    addRows(1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addRows(5, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addRows(1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11);
    addRows(1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
    addRows(5, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
    addRows(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);
    addRows(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].key, 2'b11);
      checkOutput($sformatf("vec%0d level", i),   int'(kb_high.key_level),   int'(vecs[i].level));
      checkOutput($sformatf("vec%0d press", i),   int'(kb_high.key_press),   int'(vecs[i].press));
      checkOutput($sformatf("vec%0d release", i), int'(kb_high.key_release), int'(vecs[i].rel));
      checkOutput($sformatf("vec%0d fake", i),    int'(kb_high.fake_switch), int'(vecs[i].fake));
      checkOutput($sformatf("vec%0d long", i),    int'(kb_high.key_long),    0);
    end

    // Bounce on key 0: the key reads 1,0,1,0,1 and then holds at 1.
    // The final rising sample is edge 5, so the press lands on edge 10.
    // With long press enabled, key_long follows on edge 20.
    press_n = 0; press_at = 0; long_n = 0; long_at = 0;
    for (int e = 1; e <= 35; e++) begin
      k = 2'b00;
      if (e <= 5) k[0] = (e % 2 == 1);
      else        k[0] = 1'b1;
      applyStimulus(1'b0, k, 2'b11);
      if (kb_high.key_press != 2'b00) begin press_n++; press_at = e; end
      if (kb_high.key_long  != 2'b00) begin long_n++;  long_at  = e; end
    end
    checkOutput("bounce press count", press_n, 1);
    checkOutput("bounce press edge",  press_at, 10);
    checkOutput("bounce level",       int'(kb_high.key_level),   1);
    checkOutput("bounce fake",        int'(kb_high.fake_switch), 2);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    exp_long_n = 1;
    checkOutput("long pulse edge", long_at, 20);
`else
    exp_long_n = 0;
`endif
    checkOutput("long pulse count", long_n, exp_long_n);

    // Glitch on key 1: a 3-cycle high glitch must not produce a press.
    // Key 0 stays held, and its saturated hold counter must stay quiet.
    for (int e = 1; e <= 3; e++) applyStimulus(1'b0, 2'b11, 2'b11);
    watchEvents(2'b01, 2'b11, 12, 0, ev, at, val);
    checkOutput("glitch press count", ev, 0);
    watchEvents(2'b01, 2'b11, 4, 3, ev, at, val);
    checkOutput("held long repeat", ev, 0);
    checkOutput("glitch level", int'(kb_high.key_level), 1);

    // Release key 0: expect a release pulse on edge 6, with fake_switch unchanged.
    watchEvents(2'b00, 2'b11, 8, 1, ev, at, val);
    checkOutput("release count", ev, 1);
    checkOutput("release edge", at, 6);
    checkOutput("release value", val, 1);
    checkOutput("release fake", int'(kb_high.fake_switch), 2);

    // Simultaneous press: both channels must report in the same cycle.
    watchEvents(2'b11, 2'b11, 8, 0, ev, at, val);
    checkOutput("simul count", ev, 1);
    checkOutput("simul edge", at, 6);
    checkOutput("simul value", val, 3);
    checkOutput("simul fake", int'(kb_high.fake_switch), 1);

    // Press key 1 twice more: fake_switch[1] should follow 0 -> 1 -> 0.
    watchEvents(2'b01, 2'b11, 8, 1, ev, at, val);
    checkOutput("key1 release value", val, 2);
    watchEvents(2'b11, 2'b11, 8, 0, ev, at, val);
    checkOutput("key1 press2 fake", int'(kb_high.fake_switch[1]), 1);
    watchEvents(2'b01, 2'b11, 8, 1, ev, at, val);
    watchEvents(2'b11, 2'b11, 8, 0, ev, at, val);
    checkOutput("key1 press3 value", val, 2);
    checkOutput("key1 press3 fake", int'(kb_high.fake_switch[1]), 0);

    // Active-low instance: key 0 driven 1 -> 0 must give a press on edge 6.
    checkOutput("low idle level", int'(kb_low.key_level), 0);
    watchEvents(2'b11, 2'b10, 8, 2, ev, at, val);
    checkOutput("low press count", ev, 1);
    checkOutput("low press edge", at, 6);
    checkOutput("low press value", val, 1);
    checkOutput("low level", int'(kb_low.key_level), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
